// File: rtl/zx_video_pkg.sv
// zx_video_pkg -- shared constants and helpers for the ZX Spectrum style video block.
//   * RGB565 component levels (off / normal / bright)
//   * attribute byte field positions and {G,R,B} colour bit positions
//   * ZX screen geometry (256x192 pixels, 32 character columns) and its 2x2 scaled size
//   * base address of the attribute area in screen memory
//   * colour_to_rgb(): 3-bit ZX colour plus bright flag to an RGB565 pixel
package zx_video_pkg;

    localparam logic [4:0] LVL5_OFF    = 5'h00;
    localparam logic [4:0] LVL5_NORM   = 5'h18;
    localparam logic [4:0] LVL5_BRIGHT = 5'h1F;
    localparam logic [5:0] LVL6_OFF    = 6'h00;
    localparam logic [5:0] LVL6_NORM   = 6'h30;
    localparam logic [5:0] LVL6_BRIGHT = 6'h3F;

    localparam int ATTR_INK_LSB   = 0;
    localparam int ATTR_PAPER_LSB = 3;
    localparam int ATTR_BRIGHT    = 6;
    localparam int ATTR_FLASH     = 7;

    // Colour triplets are ordered {G,R,B}.
    localparam int COL_B = 0;
    localparam int COL_R = 1;
    localparam int COL_G = 2;

    localparam int ZX_WIDTH  = 256;
    localparam int ZX_HEIGHT = 192;
    localparam int ZX_COLS   = 32;
    localparam int ACTIVE_W  = 2 * ZX_WIDTH;
    localparam int ACTIVE_H  = 2 * ZX_HEIGHT;

    localparam logic [12:0] ATTR_BASE = 13'h1800;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    function automatic rgb565_t colour_to_rgb(input logic [2:0] col, input logic bright);
        rgb565_t    px;
        logic [4:0] l5;
        logic [5:0] l6;
        l5   = bright ? LVL5_BRIGHT : LVL5_NORM;
        l6   = bright ? LVL6_BRIGHT : LVL6_NORM;
        px.r = col[COL_R] ? l5 : LVL5_OFF;
        px.g = col[COL_G] ? l6 : LVL6_OFF;
        px.b = col[COL_B] ? l5 : LVL5_OFF;
        return px;
    endfunction

endpackage

// File: rtl/zx_video_timing.sv
// zx_video_timing -- pixel-tick divider, raster counters, sync and frame pulse.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   tick            : high for one clk in every CLK_DIV (the pixel tick)
//   x, y            : current raster position, advanced on each tick
//   hs, vs          : registered syncs, valid one tick after the position they describe
//   frame_irq       : one-clk pulse on the tick at x=0 of line V_VISIBLE+V_FRONT
module zx_video_timing #(
    parameter int   CLK_DIV   = 4,
    parameter int   H_VISIBLE = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_VISIBLE = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter logic HS_POL    = 1'b1,
    parameter logic VS_POL    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        tick,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        hs,
    output logic        vs,
    output logic        frame_irq
);
    localparam int DIV_W    = $clog2(CLK_DIV);
    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    logic [DIV_W-1:0] div_q, div_d;
    logic [11:0]      x_q, x_d, y_q, y_d;
    logic             hs_q, hs_d, vs_q, vs_d, irq_q, irq_d;
    logic             tick_s;

    // The tick is the last count of the free-running divider, so the first
    // tick after reset lands CLK_DIV clocks later.
    assign tick_s = (div_q == DIV_W'(CLK_DIV - 1));

    // Next-state for divider, raster counters and sync/frame outputs.
    always_comb begin
        div_d = div_q + DIV_W'(1);
        if (tick_s) begin
            if (x_q == 12'(H_TOTAL - 1)) begin
                x_d = 12'd0;
                if (y_q == 12'(V_TOTAL - 1)) begin
                    y_d = 12'd0;
                end else begin
                    y_d = y_q + 12'd1;
                end
            end else begin
                x_d = x_q + 12'd1;
                y_d = y_q;
            end
            hs_d  = ((x_q >= 12'(HS_START)) && (x_q < 12'(HS_END))) ? HS_POL : ~HS_POL;
            vs_d  = ((y_q >= 12'(VS_START)) && (y_q < 12'(VS_END))) ? VS_POL : ~VS_POL;
            irq_d = (x_q == 12'd0) && (y_q == 12'(VS_START));
        end else begin
            x_d   = x_q;
            y_d   = y_q;
            hs_d  = hs_q;
            vs_d  = vs_q;
            irq_d = 1'b0;
        end
    end

    // Timing state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            x_q   <= 12'd0;
            y_q   <= 12'd0;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            irq_q <= 1'b0;
        end else begin
            div_q <= div_d;
            x_q   <= x_d;
            y_q   <= y_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            irq_q <= irq_d;
        end
    end

    assign tick      = tick_s;
    assign x         = x_q;
    assign y         = y_q;
    assign hs        = hs_q;
    assign vs        = vs_q;
    assign frame_irq = irq_q;

endmodule

// File: rtl/zx_video.sv
// zx_video -- ZX Spectrum screen (256x192, 2x2 scaled) on a VGA-style raster.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   border[2:0]         : border colour {G,R,B}, taken at the start of each line
//   video_addr[12:0]    : screen memory byte address (bitmap / attributes)
//   video_data[7:0]     : memory read data, valid one tick after video_addr changes
//   red/green/blue      : registered RGB565 pixel, one tick behind the raster position
//   hs, vs, frame_irq   : registered syncs and per-frame pulse from zx_video_timing
module zx_video
    import zx_video_pkg::*;
#(
    parameter int   CLK_DIV      = 4,
    parameter int   H_VISIBLE    = 640,
    parameter int   H_FRONT      = 16,
    parameter int   H_SYNC       = 96,
    parameter int   H_BACK       = 48,
    parameter int   V_VISIBLE    = 480,
    parameter int   V_FRONT      = 10,
    parameter int   V_SYNC       = 2,
    parameter int   V_BACK       = 33,
    parameter int   BORDER_X     = 64,
    parameter int   BORDER_Y     = 48,
    parameter logic HS_POL       = 1'b1,
    parameter logic VS_POL       = 1'b1,
    parameter int   FLASH_FRAMES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  border,
    output logic [12:0] video_addr,
    input  logic [7:0]  video_data,
    output logic [4:0]  red,
    output logic [5:0]  green,
    output logic [4:0]  blue,
    output logic        hs,
    output logic        vs,
    output logic        frame_irq
);
    logic        tick_s;
    logic [11:0] x_s, y_s;

    zx_video_timing #(
        .CLK_DIV   (CLK_DIV),
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK),
        .HS_POL    (HS_POL),
        .VS_POL    (VS_POL)
    ) u_timing (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick_s),
        .x         (x_s),
        .y         (y_s),
        .hs        (hs),
        .vs        (vs),
        .frame_irq (frame_irq)
    );

    logic [12:0] video_addr_q, video_addr_d;
    logic [7:0]  bmp_hold_q, bmp_hold_d, attr_hold_q, attr_hold_d;
    logic [7:0]  disp_q, disp_d, attr_q, attr_d;
    logic [2:0]  border_line_q, border_line_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        flash_q, flash_d;
    rgb565_t     rgb_q, rgb_d;

    logic [11:0] dx_s, dy_s, pre_s;
    logic [3:0]  phase_s;
    logic [7:0]  zy_s;
    logic [4:0]  xn_s;
    logic        visible_s, in_act_s, fetch_s, pix_bit_s;
    logic [2:0]  line_border_s, ink_s, paper_s, col_s;

    // Raster position relative to the active picture and current pixel colour.
    // Offsets wrap modulo 4096, so positions left/above the picture compare as
    // large values and fall outside the unsigned range checks.
    always_comb begin
        dx_s      = x_s - 12'(BORDER_X);
        dy_s      = y_s - 12'(BORDER_Y);
        // pre_s shifts the cell grid one cell early, covering the prefetch cell
        // just left of the picture; its cell index is the next cell's column.
        pre_s     = dx_s + 12'd16;
        phase_s   = dx_s[3:0];
        zy_s      = dy_s[8:1];
        xn_s      = pre_s[8:4];
        visible_s = (x_s < 12'(H_VISIBLE)) && (y_s < 12'(V_VISIBLE));
        in_act_s  = (dx_s < 12'(ACTIVE_W)) && (dy_s < 12'(ACTIVE_H)) && visible_s;
        fetch_s   = (pre_s < 12'(ACTIVE_W)) && (dy_s < 12'(ACTIVE_H));
        if (x_s == 12'd0) begin
            line_border_s = border;
        end else begin
            line_border_s = border_line_q;
        end
        // Each ZX pixel spans two ticks: phase[3:1] picks the bit, MSB first.
        pix_bit_s = disp_q[~phase_s[3:1]];
        ink_s     = attr_q[ATTR_INK_LSB +: 3];
        paper_s   = attr_q[ATTR_PAPER_LSB +: 3];
        if (attr_q[ATTR_FLASH] && flash_q) begin
            col_s = pix_bit_s ? paper_s : ink_s;
        end else begin
            col_s = pix_bit_s ? ink_s : paper_s;
        end
    end

    // Next-state for fetch address, holding/display registers, pixel and flash.
    always_comb begin
        video_addr_d  = video_addr_q;
        bmp_hold_d    = bmp_hold_q;
        attr_hold_d   = attr_hold_q;
        disp_d        = disp_q;
        attr_d        = attr_q;
        border_line_d = border_line_q;
        frame_cnt_d   = frame_cnt_q;
        flash_d       = flash_q;
        rgb_d         = rgb_q;
        if (tick_s) begin
            if (x_s == 12'd0) begin
                border_line_d = border;
            end else begin
                border_line_d = border_line_q;
            end
            if (fetch_s) begin
                case (phase_s)
                    4'd0:    video_addr_d = {zy_s[7:6], zy_s[2:0], zy_s[5:3], xn_s};
                    4'd4:    video_addr_d = ATTR_BASE | {3'b000, zy_s[7:3], xn_s};
                    default: video_addr_d = video_addr_q;
                endcase
            end else begin
                video_addr_d = video_addr_q;
            end
            case (phase_s)
                4'd1: bmp_hold_d = video_data;
                4'd5: attr_hold_d = video_data;
                4'd15: begin
                    disp_d = bmp_hold_q;
                    attr_d = attr_hold_q;
                end
                default: bmp_hold_d = bmp_hold_q;
            endcase
            if (in_act_s) begin
                rgb_d = colour_to_rgb(col_s, attr_q[ATTR_BRIGHT]);
            end else if (visible_s) begin
                rgb_d = colour_to_rgb(line_border_s, 1'b0);
            end else begin
                rgb_d = rgb565_t'(16'h0000);
            end
            if ((x_s == 12'd0) && (y_s == 12'd0)) begin
                if (frame_cnt_q == 16'(FLASH_FRAMES - 1)) begin
                    frame_cnt_d = 16'd0;
                    flash_d     = ~flash_q;
                end else begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    flash_d     = flash_q;
                end
            end else begin
                frame_cnt_d = frame_cnt_q;
                flash_d     = flash_q;
            end
        end else begin
            rgb_d = rgb_q;
        end
    end

    // Pixel pipeline and flash state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            video_addr_q  <= 13'h0000;
            bmp_hold_q    <= 8'h00;
            attr_hold_q   <= 8'h00;
            disp_q        <= 8'h00;
            attr_q        <= 8'h00;
            border_line_q <= 3'b000;
            frame_cnt_q   <= 16'd0;
            flash_q       <= 1'b0;
            rgb_q         <= rgb565_t'(16'h0000);
        end else begin
            video_addr_q  <= video_addr_d;
            bmp_hold_q    <= bmp_hold_d;
            attr_hold_q   <= attr_hold_d;
            disp_q        <= disp_d;
            attr_q        <= attr_d;
            border_line_q <= border_line_d;
            frame_cnt_q   <= frame_cnt_d;
            flash_q       <= flash_d;
            rgb_q         <= rgb_d;
        end
    end

    assign video_addr = video_addr_q;
    assign red        = rgb_q.r;
    assign green      = rgb_q.g;
    assign blue       = rgb_q.b;

endmodule
